// File: rtl/fc_irq_ctrl.sv
// Interrupt controller for the fabric-controller core: synchronises event lines,
// latches edge events into PENDING, masks them onto irq_o, and exposes an APB register file.
module fc_irq_ctrl #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter logic [31:0] MASK_RST       = 32'hFFFF_FFFF,
  parameter logic [31:0] LEVEL_RST      = 32'h0000_0800
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [31:0]               events_i,
  output logic [31:0]               irq_o,
  input  logic                      core_irq_ack_i,
  input  logic [4:0]                core_irq_ack_id_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o
);

  localparam logic [2:0] REG_MASK     = 3'd0;
  localparam logic [2:0] REG_MASK_SET = 3'd1;
  localparam logic [2:0] REG_MASK_CLR = 3'd2;
  localparam logic [2:0] REG_PENDING  = 3'd3;
  localparam logic [2:0] REG_INT_SET  = 3'd4;
  localparam logic [2:0] REG_INT_CLR  = 3'd5;
  localparam logic [2:0] REG_MODE     = 3'd6;
  localparam logic [2:0] REG_LAST_ACK = 3'd7;

  logic [31:0] s1, s2, s2_d;
  logic [31:0] pending, mask, mode;
  logic        ack_valid;
  logic [4:0]  ack_id;

  logic        access, addr_ok, wr, rd;
  logic [2:0]  idx;
  logic [31:0] rise, set_vec, clr_vec, ack_vec, pending_nxt;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^paddr_i[1:0];

  assign access  = psel_i & penable_i;
  assign addr_ok = (paddr_i[APB_ADDR_WIDTH-1:5] == '0);
  assign idx     = paddr_i[4:2];
  assign wr      = access & pwrite_i & addr_ok;
  assign rd      = access & ~pwrite_i & addr_ok;

  assign rise    = s2 & ~s2_d;
  assign ack_vec = core_irq_ack_i ? (32'h1 << core_irq_ack_id_i) : 32'h0;
  assign set_vec = rise | ((wr && idx == REG_INT_SET) ? pwdata_i : 32'h0);
  assign clr_vec = ack_vec | ((wr && idx == REG_INT_CLR) ? pwdata_i : 32'h0);

  // Set beats clear so an event arriving with its own ack is never dropped.
  assign pending_nxt = (mode & s2) | (~mode & ((pending & ~clr_vec) | set_vec));

  assign irq_o    = pending & mask;
  assign pready_o = 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1        <= '0;
      s2        <= '0;
      s2_d      <= '0;
      pending   <= '0;
      mask      <= MASK_RST;
      mode      <= LEVEL_RST;
      ack_valid <= 1'b0;
      ack_id    <= '0;
    end else begin
      s1      <= events_i;
      s2      <= s1;
      s2_d    <= s2;
      pending <= pending_nxt;
      if (wr) begin
        case (idx)
          REG_MASK:     mask <= pwdata_i;
          REG_MASK_SET: mask <= mask | pwdata_i;
          REG_MASK_CLR: mask <= mask & ~pwdata_i;
          REG_MODE:     mode <= pwdata_i;
          default:      ;
        endcase
      end
      // A fresh ack overrides the read-to-clear of the valid flag.
      if (core_irq_ack_i) begin
        ack_valid <= 1'b1;
        ack_id    <= core_irq_ack_id_i;
      end else if (rd && idx == REG_LAST_ACK) begin
        ack_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    prdata_o  = 32'h0;
    pslverr_o = 1'b0;
    if (access) begin
      if (!addr_ok) begin
        pslverr_o = 1'b1;
      end else if (pwrite_i) begin
        pslverr_o = (idx == REG_PENDING) || (idx == REG_LAST_ACK);
      end else begin
        case (idx)
          REG_MASK:     prdata_o = mask;
          REG_PENDING:  prdata_o = pending;
          REG_MODE:     prdata_o = mode;
          REG_LAST_ACK: prdata_o = {23'h0, ack_valid, 3'b000, ack_id};
          default:      prdata_o = 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_irq_ctrl.sv
// Scoreboard bench for fc_irq_ctrl: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_fc_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] events;
  logic [31:0] irq;
  logic        ack;
  logic [4:0]  ack_id;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  fc_irq_ctrl #(.APB_ADDR_WIDTH(12)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .events_i          (events),
    .irq_o             (irq),
    .core_irq_ack_i    (ack),
    .core_irq_ack_id_i (ack_id),
    .psel_i            (psel),
    .penable_i         (penable),
    .pwrite_i          (pwrite),
    .paddr_i           (paddr),
    .pwdata_i          (pwdata),
    .prdata_o          (prdata),
    .pready_o          (pready),
    .pslverr_o         (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1;
    err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1;
    d   = prdata;
    err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_ack(input logic [4:0] id);
    ack = 1'b1; ack_id = id;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;

    rst_ni = 1'b0; events = '0; ack = 1'b0; ack_id = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

    // Reset state
    #12;
    push_exp("rst_irq", 32'h0);     pop_cmp(irq);
    push_exp("rst_prdata", 32'h0);  pop_cmp(prdata);
    push_exp("rst_pslverr", 32'h0); pop_cmp({31'h0, pslverr});
    push_exp("rst_pready", 32'h1);  pop_cmp({31'h0, pready});
    #3 rst_ni = 1'b1;
    tick();
    apb_rd(12'h000, rd, err); push_exp("rst_mask", 32'hFFFF_FFFF); pop_cmp(rd);
    apb_rd(12'h018, rd, err); push_exp("rst_mode", 32'h0000_0800); pop_cmp(rd);
    apb_rd(12'h00C, rd, err); push_exp("rst_pending", 32'h0);      pop_cmp(rd);
    apb_rd(12'h01C, rd, err); push_exp("rst_last_ack", 32'h0);     pop_cmp(rd);

    // Edge line 3: latency, ack, LAST_ACK read-clear
    events[3] = 1'b1; tick(); events[3] = 1'b0;
    tick();
    push_exp("e3_early", 32'h0); pop_cmp(irq);
    tick();
    push_exp("e3_irq", 32'h8); pop_cmp(irq);
    do_ack(5'd3);
    push_exp("e3_acked", 32'h0); pop_cmp(irq);
    apb_rd(12'h01C, rd, err); push_exp("last_ack_1", 32'h103); pop_cmp(rd);
    apb_rd(12'h01C, rd, err); push_exp("last_ack_2", 32'h003); pop_cmp(rd);

    // Level line 11
    events[11] = 1'b1;
    tick(2);
    push_exp("l11_early", 32'h0); pop_cmp(irq);
    tick();
    push_exp("l11_on", 32'h800); pop_cmp(irq);
    do_ack(5'd11);
    push_exp("l11_ack_noeff", 32'h800); pop_cmp(irq);
    events[11] = 1'b0;
    tick(2);
    push_exp("l11_hold", 32'h800); pop_cmp(irq);
    tick();
    push_exp("l11_off", 32'h0); pop_cmp(irq);

    // Masked pending line 4
    apb_wr(12'h008, 32'h10, err);
    events[4] = 1'b1; tick(); events[4] = 1'b0;
    tick(3);
    apb_rd(12'h00C, rd, err); push_exp("m4_pending", 32'h10); pop_cmp(rd);
    push_exp("m4_masked", 32'h0); pop_cmp(irq);
    apb_rd(12'h000, rd, err); push_exp("m4_mask", 32'hFFFF_FFEF); pop_cmp(rd);
    apb_wr(12'h004, 32'h10, err);
    push_exp("m4_unmasked", 32'h10); pop_cmp(irq);
    do_ack(5'd4);
    push_exp("m4_acked", 32'h0); pop_cmp(irq);

    // Line 7: set wins over ack and over INT_CLR
    events[7] = 1'b1; tick(); events[7] = 1'b0;
    tick(4);
    push_exp("l7_pend", 32'h80); pop_cmp(irq);
    events[7] = 1'b1; tick(); events[7] = 1'b0;
    tick();
    do_ack(5'd7);
    push_exp("l7_rise_vs_ack", 32'h80); pop_cmp(irq);
    tick(3);
    events[7] = 1'b1; tick(); events[7] = 1'b0;
    apb_wr(12'h014, 32'h80, err);
    push_exp("l7_rise_vs_clr", 32'h80); pop_cmp(irq);
    tick(3);
    apb_wr(12'h014, 32'h80, err);
    push_exp("l7_clr", 32'h0); pop_cmp(irq);

    // INT_SET / INT_CLR / error responses
    apb_wr(12'h010, 32'h1, err);
    push_exp("set0", 32'h1); pop_cmp(irq);
    push_exp("set0_err", 32'h0); pop_cmp({31'h0, err});
    apb_wr(12'h014, 32'h1, err);
    push_exp("clr0", 32'h0); pop_cmp(irq);
    apb_wr(12'h00C, 32'hFFFF_FFFF, err);
    push_exp("wr_ro_err", 32'h1); pop_cmp({31'h0, err});
    apb_rd(12'h00C, rd, err); push_exp("wr_ro_pending", 32'h0); pop_cmp(rd);
    apb_rd(12'h004, rd, err); push_exp("rd_wo_zero", 32'h0); pop_cmp(rd);
    apb_rd(12'h020, rd, err);
    push_exp("bad_addr_rd_err", 32'h1); pop_cmp({31'h0, err});
    push_exp("bad_addr_rd_data", 32'h0); pop_cmp(rd);
    apb_wr(12'h020, 32'h0, err);
    push_exp("bad_addr_wr_err", 32'h1); pop_cmp({31'h0, err});
    apb_rd(12'h000, rd, err); push_exp("bad_addr_mask", 32'hFFFF_FFFF); pop_cmp(rd);

    // Level-to-edge mode change keeps pending, no spurious edge
    events[11] = 1'b1;
    tick(3);
    push_exp("mode_lvl_on", 32'h800); pop_cmp(irq);
    apb_wr(12'h018, 32'h0, err);
    tick(2);
    push_exp("mode_edge_keep", 32'h800); pop_cmp(irq);
    apb_wr(12'h014, 32'h800, err);
    tick(3);
    push_exp("mode_no_spurious", 32'h0); pop_cmp(irq);
    apb_wr(12'h018, 32'h800, err);
    tick();
    push_exp("mode_lvl_back", 32'h800); pop_cmp(irq);
    events[11] = 1'b0;
    tick(3);
    push_exp("mode_lvl_off", 32'h0); pop_cmp(irq);

    // Asynchronous reset mid-operation
    apb_wr(12'h010, 32'hFFFF_F7FF, err);
    push_exp("pre_rst_irq", 32'hFFFF_F7FF); pop_cmp(irq);
    apb_wr(12'h008, 32'h0000_00FF, err);
    #2 rst_ni = 1'b0;
    #1;
    push_exp("async_rst_irq", 32'h0); pop_cmp(irq);
    #3 rst_ni = 1'b1;
    tick();
    apb_rd(12'h000, rd, err); push_exp("post_rst_mask", 32'hFFFF_FFFF); pop_cmp(rd);
    apb_rd(12'h018, rd, err); push_exp("post_rst_mode", 32'h800);       pop_cmp(rd);
    apb_rd(12'h00C, rd, err); push_exp("post_rst_pending", 32'h0);      pop_cmp(rd);

    if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
